// File: rtl/imem_pkg.sv
// Shared constants and state type for the instruction-memory boot controller.
package imem_pkg;

    localparam int          NUM_OF_INST = 1024;
    localparam logic [31:0] NOP_INSN    = 32'h00000013;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot/reload sequencer: clears instruction memory to NOP, streams a program in
// from the loader, then releases the core and leaves the read port to fetch.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int NUM_OF_INST = imem_pkg::NUM_OF_INST,
    parameter int ADDR_W      = $clog2(NUM_OF_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    input  logic              reload_req,
    input  logic [31:0]       pc_address,
    output logic              fetch_fault,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_OF_INST - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W:0]     r_clear_addr;
    logic [ADDR_W:0]     r_load_count;
    logic                r_overflow;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_waddr;
    logic [31:0]         r_mem_wdata;

    logic                w_accept;
    logic                w_final;
    logic                w_clear_done;

    // clear_addr carries one extra bit so it can sit at NUM_OF_INST for the
    // cycle after the last NOP write, which is what moves the FSM to LOAD.
    assign w_clear_done = r_clear_addr[ADDR_W];
    assign w_accept     = (r_state == LOAD) && load_valid;
    assign w_final      = w_accept && (load_last || (r_load_count == LAST_IDX));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment up front keeps this block free of latches
    // on paths where no case arm changes the state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAR:   if (w_clear_done) w_next_state = LOAD;
            LOAD:    if (w_final)      w_next_state = RUN;
            RUN:     if (reload_req)   w_next_state = CLEAR;
            default:                   w_next_state = CLEAR;
        endcase
    end

    always_comb begin
        load_ready = (r_state == LOAD);
        core_hold  = (r_state != RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clear_addr <= '0;
            r_load_count <= '0;
            r_overflow   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_load_count <= '0;
                    if (!w_clear_done) begin
                        r_mem_we     <= 1'b1;
                        r_mem_waddr  <= r_clear_addr[ADDR_W-1:0];
                        r_mem_wdata  <= NOP_INSN;
                        r_clear_addr <= r_clear_addr + CNT_ONE;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_mem_we     <= 1'b1;
                        r_mem_waddr  <= r_load_count[ADDR_W-1:0];
                        r_mem_wdata  <= load_data;
                        r_load_count <= r_load_count + CNT_ONE;
                        if (w_final && !load_last) r_overflow <= 1'b1;
                    end
                end
                RUN: begin
                    if (reload_req) begin
                        r_clear_addr <= '0;
                        r_overflow   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_waddr   = r_mem_waddr;
    assign mem_wdata   = r_mem_wdata;
    assign load_count  = r_load_count;
    assign overflow    = r_overflow;

    // Read port is never arbitrated; the core is held whenever reads are stale.
    assign mem_raddr   = pc_address[ADDR_W+1:2];
    assign fetch_fault = (|pc_address[1:0]) || (|pc_address[31:ADDR_W+2]);

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl with an 8-word memory, randomized
// program data and a shadow memory compared against an expected image.
module tb_imem_boot_ctrl;

    localparam int          N   = 8;
    localparam int          AW  = 3;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [31:0]   load_data;
    logic          load_last;
    logic          reload_req;
    logic [31:0]   pc_address;
    logic          fetch_fault;
    logic [AW-1:0] mem_raddr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic [AW:0]   load_count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog      [N];
    logic [31:0] model_mem [N];
    logic [31:0] dut_mem   [N];

    imem_boot_ctrl #(.NUM_OF_INST(N), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .reload_req  (reload_req),
        .pc_address  (pc_address),
        .fetch_fault (fetch_fault),
        .mem_raddr   (mem_raddr),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .core_hold   (core_hold),
        .load_count  (load_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Shadow of the instruction memory as written through the write port.
    always @(negedge clk) begin
        if (!rst && mem_we) dut_mem[mem_waddr] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_we",     mem_we,     0);
        check("rst_mem_waddr",  mem_waddr,  0);
        check("rst_mem_wdata",  mem_wdata,  0);
        check("rst_load_ready", load_ready, 0);
        check("rst_core_hold",  core_hold,  1);
        check("rst_load_count", load_count, 0);
        check("rst_overflow",   overflow,   0);
    endtask

    // Expect N consecutive NOP writes to 0..N-1, then load_ready one cycle later.
    task automatic clear_check();
        for (int i = 0; i < N; i++) begin
            step();
            check("clr_we",    mem_we,     1);
            check("clr_addr",  mem_waddr,  i);
            check("clr_data",  mem_wdata,  NOP);
            check("clr_hold",  core_hold,  1);
            check("clr_ready", load_ready, 0);
            check("clr_count", load_count, 0);
        end
        step();
        check("clr_end_we",    mem_we,     0);
        check("clr_end_ready", load_ready, 1);
        check("clr_end_hold",  core_hold,  1);
        for (int i = 0; i < N; i++) model_mem[i] = NOP;
    endtask

    task automatic compare_mem();
        for (int i = 0; i < N; i++)
            check($sformatf("mem[%0d]", i), dut_mem[i], model_mem[i]);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) prog[i] = $urandom;
    endtask

    // Streams prog[0..n-1]; when gapped, valid drops every other cycle and the
    // idle cycles carry random reload requests that must be ignored in LOAD.
    task automatic load_prog(input int n, input bit gapped, input bit with_last, input bit partial);
        int k;
        int budget;
        bit v;
        k = 0;
        budget = 0;
        while (k < n && budget < 64) begin
            v          = gapped ? ((budget % 2) == 0) : 1'b1;
            load_valid = v;
            load_data  = prog[k];
            load_last  = with_last && (k == n - 1);
            reload_req = (gapped && !v) ? 1'($urandom_range(0, 1)) : 1'b0;
            check("ld_ready", load_ready, 1);
            check("ld_hold",  core_hold,  1);
            step();
            if (v) begin
                check("ld_we",    mem_we,    1);
                check("ld_addr",  mem_waddr, k);
                check("ld_data",  mem_wdata, prog[k]);
                model_mem[k] = prog[k];
                k++;
                check("ld_count", load_count, k);
            end else begin
                check("ld_no_write", mem_we, 0);
            end
            budget++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        reload_req = 1'b0;
        check("ld_accepted", k, n);
        if (!partial) begin
            check("run_hold",     core_hold,  0);
            check("run_ready",    load_ready, 0);
            check("run_count",    load_count, n);
            check("run_overflow", overflow,   (n == N) && !with_last);
            step();
            check("run_we", mem_we, 0);
            compare_mem();
        end
    endtask

    task automatic fetch_one(input logic [31:0] pc);
        pc_address = pc;
        #1;
        check("fetch_raddr", mem_raddr, (pc / 4) % N);
        check("fetch_fault", fetch_fault, ((pc % 4) != 0) || (pc >= 4 * N));
    endtask

    task automatic fetch_checks();
        fetch_one(32'h0000001C);
        fetch_one(32'h00000022);
        fetch_one(32'h00000020);
        for (int i = 0; i < 6; i++) fetch_one($urandom_range(0, 4 * N + 7));
        fetch_one($urandom);
        check("fetch_hold", core_hold, 0);
    endtask

    task automatic reload();
        reload_req = 1'b1;
        step();
        reload_req = 1'b0;
        check("rl_hold",     core_hold,  1);
        check("rl_overflow", overflow,   0);
        check("rl_ready",    load_ready, 0);
        check("rl_we",       mem_we,     0);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        reload_req = 1'b0;
        pc_address = '0;
        step();
        step();
        check_reset_outputs();
        rst = 1'b0;
        clear_check();

        prog[0] = 32'h00500093;
        prog[1] = 32'h00100113;
        prog[2] = 32'h002081B3;
        load_prog(3, 1'b0, 1'b1, 1'b0);
        fetch_checks();

        reload();
        clear_check();
        fill_random(5);
        load_prog(5, 1'b1, 1'b1, 1'b0);

        reload();
        clear_check();
        fill_random(N);
        load_prog(N, 1'b0, 1'b0, 1'b0);
        load_valid = 1'b1;
        load_data  = $urandom;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ninth_we",    mem_we,     0);
            check("ninth_ready", load_ready, 0);
            check("ninth_count", load_count, N);
        end
        load_valid = 1'b0;
        fetch_checks();

        reload();
        clear_check();
        fill_random(2);
        load_prog(2, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        step();
        rst = 1'b0;
        clear_check();
        fill_random(4);
        load_prog(4, 1'b1, 1'b1, 1'b0);
        fetch_checks();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/reload sequencer and port owner for the single-cycle core's instruction memory. After reset it fills every word with NOP, streams a program in over a valid/ready loader interface, then releases the core and hands the read port to fetch. It sits between the loader (UART/debug bridge), the instruction memory write/read ports and the core's stall input.

## Interface
- NUM_OF_INST, 1024: instruction memory depth in words (power of two).
- ADDR_W, $clog2(NUM_OF_INST): word-address width.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  loader word valid.
- load_ready  out  1  controller can accept a loader word.
- load_data  in  32  instruction word.
- load_last  in  1  qualifies the final word of the program.
- reload_req  in  1  single-cycle request to restart clear+load; honoured only in RUN.
- pc_address  in  32  byte address from fetch.
- fetch_fault  out  1  pc misaligned (pc[1:0]≠0) or beyond depth (pc[31:ADDR_W+2]≠0); combinational.
- mem_raddr  out  ADDR_W  word read address = pc_address[ADDR_W+1:2]; combinational.
- mem_we  out  1  registered write enable.
- mem_waddr  out  ADDR_W  registered write address.
- mem_wdata  out  32  registered write data.
- core_hold  out  1  stalls the core; 1 in all states except RUN.
- load_count  out  ADDR_W+1  words accepted in the current load.
- overflow  out  1  sticky: memory filled without load_last.

## Operation
- States: CLEAR → LOAD → RUN; RUN → CLEAR on reload_req. No other transitions.
- CLEAR: clear_addr counts 0..NUM_OF_INST-1, writing NOP (32'h00000013) once per cycle. After the write to NUM_OF_INST-1 is issued, go to LOAD. load_count is zeroed.
- LOAD: load_ready=1. A word is accepted on a cycle with load_valid && load_ready. Accepted word goes to address load_count. load_count increments.
- LOAD exit: go to RUN when the accepted word has load_last=1, or when it is word NUM_OF_INST-1. If that final word is accepted with load_last=0, set overflow.
- RUN: core_hold=0. load_ready=0, so loader words are ignored. mem_we=0.
- reload_req in RUN: enter CLEAR and clear overflow. reload_req in CLEAR or LOAD is ignored.
- Read port is never arbitrated. mem_raddr always follows pc; the core is held, so reads outside RUN are don't-care.

## Timing
- Reset values: state=CLEAR, clear_addr=0, load_count=0, overflow=0, mem_we=0, mem_waddr=0, mem_wdata=0, load_ready=0, core_hold=1.
- CLEAR writes: mem_we=1 for exactly NUM_OF_INST consecutive cycles. The first is at the first posedge after rst deasserts; mem_waddr steps 0,1,…,N-1 and mem_wdata=NOP.
- load_ready rises at the cycle after the last clear write is issued.
- Write latency: a word accepted at edge t appears on mem_we/mem_waddr/mem_wdata during cycle t+1, for one cycle.
- On the edge that accepts the final word, the state becomes RUN. load_ready falls and core_hold falls at that same edge; the core's first fetch overlaps the final write cycle. The memory write port completes that write before any fetch reads it (sync read).
- Throughput: one word per cycle with load_valid held high.
- reload_req at edge t: core_hold=1 from t, and the first clear write is in cycle t+1.
- rst asserted mid-CLEAR or mid-LOAD: all outputs return to reset values immediately. The clear restarts from 0 after release, and partial loads are discarded.
- load_count saturates at NUM_OF_INST and holds its final value through RUN until the next CLEAR.

## Structure
- Shared package imem_pkg holds NUM_OF_INST, NOP_INSN = 32'h00000013, and the state enum {CLEAR, LOAD, RUN}.
- Single module, no sub-modules. The FSM and the two counters (clear_addr, load_count) are small enough to stay inline.

## Test plan
All scenarios use NUM_OF_INST=8.
- Reset release: mem_we high 8 cycles with addr 0..7 and data 00000013. load_ready rises on cycle 9 and core_hold stays 1.
- Load 3 words (00500093, 00100113, 002081B3; last on the third) back-to-back: writes hit addr 0,1,2 one cycle after each accept. core_hold falls at the third accept, load_count=3, overflow=0.
- Load with load_valid gapped every other cycle: no duplicate or skipped writes, and addresses stay contiguous.
- Eight words with no load_last: all 8 written, RUN entered, overflow=1. A ninth load_valid is not accepted.
- RUN with pc=0x0000001C gives mem_raddr=7, fault=0. pc=0x00000022 gives fault=1 (misaligned). pc=0x00000020 gives fault=1 (out of range).
- reload_req in RUN after overflow: core_hold=1 and overflow=0 next cycle, and 8 NOP writes follow. rst pulsed mid-LOAD after 2 words: load_count=0, and the clear restarts at addr 0.
